// File: rtl/johnson_sequence_checker_pkg.sv
// Shared definitions for the Johnson sequence checker.
// Holds the lock FSM state encoding and the default parameter values used by
// the checker and its decoder.
package johnson_sequence_checker_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_ERR_W      = 8;
    localparam int DEFAULT_LOCK_COUNT = 4;

    // State encodings are shared with the counter-side bench, so keep them fixed.
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_e;

    // Width of the run counter: it must be able to hold LOCK_COUNT itself.
    function automatic int run_width(input int lock_count);
        return (lock_count < 2) ? 1 : $clog2(lock_count + 1);
    endfunction

endpackage

// File: rtl/johnson_sequence_checker_decode.sv
// Combinational Johnson-code decoder.
// Compares the sampled code against every one of the 2*WIDTH legal Johnson
// patterns and reports the matching index.
// Ports:
//   code_i   - Johnson-coded sample
//   idx_o    - index of the matching pattern (0 when no match)
//   legal_o  - 1 when code_i is one of the legal patterns
module johnson_sequence_checker_decode #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] code_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             legal_o
);

    // Pattern for index k of a counter shifting {q[W-2:0], ~q[W-1]}:
    // k <= W fills ones from the bottom, k > W then fills zeros from the bottom.
    function automatic logic [WIDTH-1:0] johnson_pattern(input int k);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int b = 0; b < WIDTH; b++) begin
            p[b] = (k <= WIDTH) ? (b < k) : (b >= k - WIDTH);
        end
        return p;
    endfunction

    logic [2*WIDTH-1:0] match;

    generate
        for (genvar gi = 0; gi < 2 * WIDTH; gi++) begin : g_match
            localparam logic [WIDTH-1:0] PATTERN = johnson_pattern(gi);
            assign match[gi] = (code_i == PATTERN);
        end
    endgenerate

    // Patterns are distinct, so at most one match bit is ever set.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            if (match[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign legal_o = |match;

endmodule

// File: rtl/johnson_sequence_checker.sv
// Johnson sequence checker: receive-side monitor/decoder for a Johnson counter.
// Decodes each sampled code, checks legality and the +1 step sequence, runs a
// lock FSM (UNLOCKED -> ACQUIRE -> LOCKED) and keeps a saturating error count.
// All outputs are registered, one cycle after the code_valid sample.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset, highest priority
//   code_in    - Johnson code sample
//   code_valid - code_in is sampled this cycle
//   clear_err  - zero err_count (an error in the same cycle leaves it at 1)
//   idx_out    - decoded index of the last legal sample
//   idx_valid  - pulse: idx_out updated
//   illegal    - pulse: sample was not a legal Johnson code
//   step_err   - pulse: legal code but wrong successor while LOCKED
//   wrap       - pulse: legal step from index 2*WIDTH-1 to 0
//   locked     - FSM is in LOCKED
//   err_count  - saturating count of illegal and step_err events
module johnson_sequence_checker
    import johnson_sequence_checker_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int IDX_W      = $clog2(2 * WIDTH),
    parameter int ERR_W      = DEFAULT_ERR_W,
    parameter int LOCK_COUNT = DEFAULT_LOCK_COUNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] code_in,
    input  logic             code_valid,
    input  logic             clear_err,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid,
    output logic             illegal,
    output logic             step_err,
    output logic             wrap,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam int               RUN_W    = run_width(LOCK_COUNT);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_COUNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * WIDTH - 1);

    lock_state_e      state_q;
    logic [RUN_W-1:0] run_q;
    logic [IDX_W-1:0] prev_q;     // last legal index; also drives idx_out
    logic             idx_valid_q;
    logic             illegal_q;
    logic             step_err_q;
    logic             wrap_q;
    logic             locked_q;
    logic [ERR_W-1:0] err_count_q;
    logic [ERR_W-1:0] err_count_d;

    logic [IDX_W-1:0] dec_idx;
    logic             dec_legal;
    logic [IDX_W-1:0] expected_idx;
    logic             is_next;
    logic             is_hold;
    logic             bad_step;
    logic             err_event;

    johnson_sequence_checker_decode #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decode (
        .code_i  (code_in),
        .idx_o   (dec_idx),
        .legal_o (dec_legal)
    );

    // Explicit wrap keeps the modulus correct when 2*WIDTH is not a power of two.
    assign expected_idx = (prev_q == LAST_IDX) ? '0 : prev_q + 1'b1;
    assign is_next      = (dec_idx == expected_idx);
    assign is_hold      = (dec_idx == prev_q);

    assign bad_step  = code_valid && dec_legal && (state_q == ST_LOCKED) && !is_next && !is_hold;
    assign err_event = code_valid && (!dec_legal || bad_step);

    // A clear in the same cycle as an error still counts that error.
    always_comb begin
        err_count_d = err_count_q;
        if (clear_err) begin
            err_count_d = err_event ? ERR_W'(1) : '0;
        end else if (err_event && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // run_q counts the samples of the current in-sequence run, starting at 1
    // on the sample that enters ACQUIRE. Lock happens on the correct step seen
    // while run_q == LOCK_COUNT, i.e. after LOCK_COUNT consecutive correct steps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_UNLOCKED;
            run_q       <= '0;
            prev_q      <= '0;
            idx_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            step_err_q  <= 1'b0;
            wrap_q      <= 1'b0;
            locked_q    <= 1'b0;
            err_count_q <= '0;
        end else begin
            idx_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            step_err_q  <= 1'b0;
            wrap_q      <= 1'b0;
            err_count_q <= err_count_d;

            if (code_valid) begin
                if (!dec_legal) begin
                    // Illegal code drops lock from any state; prev is kept.
                    illegal_q <= 1'b1;
                    state_q   <= ST_UNLOCKED;
                    run_q     <= '0;
                    locked_q  <= 1'b0;
                end else begin
                    idx_valid_q <= 1'b1;
                    prev_q      <= dec_idx;
                    case (state_q)
                        ST_UNLOCKED: begin
                            state_q <= ST_ACQUIRE;
                            run_q   <= RUN_W'(1);
                        end
                        ST_ACQUIRE: begin
                            if (is_next) begin
                                wrap_q <= (prev_q == LAST_IDX);
                                if (run_q >= RUN_LOCK) begin
                                    state_q  <= ST_LOCKED;
                                    locked_q <= 1'b1;
                                end else begin
                                    run_q <= run_q + 1'b1;
                                end
                            end else if (!is_hold) begin
                                // Restart the run from this sample, no error.
                                run_q <= RUN_W'(1);
                            end
                        end
                        ST_LOCKED: begin
                            if (is_next) begin
                                wrap_q <= (prev_q == LAST_IDX);
                            end else if (!is_hold) begin
                                state_q    <= ST_ACQUIRE;
                                run_q      <= RUN_W'(1);
                                step_err_q <= 1'b1;
                                locked_q   <= 1'b0;
                            end
                        end
                        default: begin
                            state_q  <= ST_UNLOCKED;
                            run_q    <= '0;
                            locked_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign idx_out   = prev_q;
    assign idx_valid = idx_valid_q;
    assign illegal   = illegal_q;
    assign step_err  = step_err_q;
    assign wrap      = wrap_q;
    assign locked    = locked_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_johnson_sequence_checker.sv
// Bench for johnson_sequence_checker (WIDTH=8, 10 ns clock).
// Directed samples carry hand-computed expected responses; a driver pushes
// them into a queue and an independent monitor pops and compares whenever the
// DUT presents a response (idx_valid or illegal).
module tb_johnson_sequence_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] code_in = 8'h00;
    logic       code_valid = 1'b0;
    logic       clear_err = 1'b0;
    logic [3:0] idx_out;
    logic       idx_valid;
    logic       illegal;
    logic       step_err;
    logic       wrap;
    logic       locked;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    johnson_sequence_checker #(
        .WIDTH      (8),
        .IDX_W      (4),
        .ERR_W      (8),
        .LOCK_COUNT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .code_in    (code_in),
        .code_valid (code_valid),
        .clear_err  (clear_err),
        .idx_out    (idx_out),
        .idx_valid  (idx_valid),
        .illegal    (illegal),
        .step_err   (step_err),
        .wrap       (wrap),
        .locked     (locked),
        .err_count  (err_count)
    );

    typedef struct packed {
        logic [3:0] idx;
        logic       iv;
        logic       ill;
        logic       step;
        logic       wrp;
        logic       lck;
        logic [7:0] err;
    } resp_t;

    typedef struct {
        resp_t      r;
        logic [7:0] code;
        int         n;
    } item_t;

    item_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    txn = 0;

    // Hand-written Johnson codes for indices 0..15.
    logic [7:0] jc [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                            8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

    // Monitor: compares each presented response against the queue head.
    always @(negedge clk) begin : monitor
        resp_t a;
        item_t e;
        if (idx_valid || illegal) begin
            a = {idx_out, idx_valid, illegal, step_err, wrap, locked, err_count};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_response: got idx=%0d ill=%b err=%0d, required no response",
                         idx_out, illegal, err_count);
            end else begin
                e = exp_q.pop_front();
                if (a !== e.r) begin
                    failures++;
                    $display("FAIL resp#%0d code=%h: got idx=%0d iv=%b ill=%b step=%b wrap=%b lock=%b err=%0d, required idx=%0d iv=%b ill=%b step=%b wrap=%b lock=%b err=%0d",
                             e.n, e.code, a.idx, a.iv, a.ill, a.step, a.wrp, a.lck, a.err,
                             e.r.idx, e.r.iv, e.r.ill, e.r.step, e.r.wrp, e.r.lck, e.r.err);
                end else begin
                    $display("resp#%0d code=%h idx=%0d ill=%b step=%b wrap=%b lock=%b err=%0d ok",
                             e.n, e.code, a.idx, a.ill, a.step, a.wrp, a.lck, a.err);
                end
            end
        end
    end

    task automatic samp(input logic [7:0] code, input logic clr, input int e_idx,
                        input logic e_ill, input logic e_step, input logic e_wrap,
                        input logic e_lock, input int e_err);
        item_t it;
        @(negedge clk);
        code_in    = code;
        code_valid = 1'b1;
        clear_err  = clr;
        it.r    = {4'(e_idx), !e_ill, e_ill, e_step, e_wrap, e_lock, 8'(e_err)};
        it.code = code;
        it.n    = txn;
        txn++;
        exp_q.push_back(it);
    endtask

    // Cycle without a sample: all pulses must stay low.
    task automatic idle(input logic clr);
        @(negedge clk);
        code_valid = 1'b0;
        clear_err  = clr;
        @(posedge clk);
        #1;
        checks++;
        if ({idx_valid, illegal, step_err, wrap} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_pulses: got iv/ill/step/wrap=%b%b%b%b, required 0000",
                     idx_valid, illegal, step_err, wrap);
        end
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if ({idx_out, idx_valid, illegal, step_err, wrap, locked, err_count} !== 17'd0) begin
            failures++;
            $display("FAIL %s: got idx=%0d iv=%b ill=%b step=%b wrap=%b lock=%b err=%0d, required all zero",
                     name, idx_out, idx_valid, illegal, step_err, wrap, locked, err_count);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_state("reset_state");
        reset = 1'b0;

        // Full loop from 0: locks on the 5th sample (4th correct step).
        for (int k = 0; k < 16; k++) begin
            samp(jc[k], 1'b0, k, 1'b0, 1'b0, 1'b0, (k >= 4), 0);
        end
        samp(jc[0], 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0);   // 15 -> 0 wrap
        samp(jc[1], 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        samp(jc[1], 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 0);   // hold, no error

        // Illegal while LOCKED: idx_out stays 1.
        samp(8'h05, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        samp(jc[1], 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        samp(jc[2], 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        samp(jc[3], 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        samp(jc[4], 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        samp(jc[5], 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1);

        // Wrong successor while LOCKED at idx 5.
        samp(8'h07, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 2);
        samp(jc[4], 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        samp(jc[5], 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        samp(jc[6], 1'b0, 6, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        samp(jc[7], 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        samp(jc[8], 1'b0, 8, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        samp(jc[9], 1'b0, 9, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        // Counter reset 9 -> 0, repeated sample, relock after 4 good steps.
        samp(jc[0], 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        samp(jc[0], 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        samp(jc[1], 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        samp(jc[2], 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        samp(jc[3], 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        samp(jc[4], 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        samp(jc[4], 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b1, 3);

        // clear_err alone.
        idle(1'b1);
        samp(jc[5], 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b1, 0);

        // Saturation: 260 illegal samples, count holds at 255.
        for (int n = 1; n <= 260; n++) begin
            samp(8'h05, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0, (n > 255) ? 255 : n);
        end
        samp(8'h05, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1);   // clear + error -> 1
        idle(1'b1);

        // ACQUIRE: off-sequence legal sample restarts the run without an error.
        samp(jc[0],  1'b0, 0,  1'b0, 1'b0, 1'b0, 1'b0, 0);
        samp(jc[7],  1'b0, 7,  1'b0, 1'b0, 1'b0, 1'b0, 0);
        samp(jc[8],  1'b0, 8,  1'b0, 1'b0, 1'b0, 1'b0, 0);
        samp(jc[9],  1'b0, 9,  1'b0, 1'b0, 1'b0, 1'b0, 0);
        samp(jc[10], 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        samp(jc[11], 1'b0, 11, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        idle(1'b0);

        // Mid-run reset returns everything to zero.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midrun_reset");
        reset = 1'b0;
        samp(jc[2], 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(1'b0);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_responses: got %0d outstanding, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
